// File: rtl/iob_eth_rx_frame_queue.sv
// Multi-frame Ethernet RX queue: packs received bytes into a ring of frame slots and
// presents committed frames to the CPU in FIFO order through a word-addressed read port.
module iob_eth_rx_frame_queue #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NSLOTS      = 4,
    parameter int unsigned SLOT_ADDR_W = 9,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned NBYTES     = DATA_W / 8,
    localparam int unsigned NB_W       = $clog2(NBYTES),
    localparam int unsigned LEN_W      = SLOT_ADDR_W + NB_W + 1,
    localparam int unsigned PTR_W      = $clog2(NSLOTS),
    localparam int unsigned Q_W        = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    input  logic                   in_err,
    input  logic                   flush,
    input  logic [SLOT_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   pop,
    output logic                   frame_avail,
    output logic [Q_W-1:0]         nframes,
    output logic [LEN_W-1:0]       head_len,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   drop_clr
);

    localparam int unsigned MAXB  = NBYTES * (2 ** SLOT_ADDR_W);
    localparam int unsigned DEPTH = NSLOTS * (2 ** SLOT_ADDR_W);
    localparam logic [LEN_W-1:0] LANE_MASK = LEN_W'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StDiscard} state_e;

    state_e state_q, state_d;
    // Set when a discard was caused by flush, so the frame end is not counted as a drop.
    logic quiet_q, quiet_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  len_q [NSLOTS];

    logic [PTR_W-1:0]  wp_q, wp_d, wp_base, rp_q, rp_d, rp_base;
    logic [Q_W-1:0]    n_q, n_d, n_base;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  bcnt_q, bcnt_d, wr_off;
    logic [DATA_W-1:0] rd_data_q;
    logic [SLOT_ADDR_W-1:0]       wr_word;
    logic [PTR_W+SLOT_ADDR_W-1:0] wr_addr;

    logic full, oversize, wr_en, commit, drop, pop_ok;

    assign full     = !flush && (n_q == Q_W'(NSLOTS));
    assign oversize = (bcnt_q == LEN_W'(MAXB));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            quiet_q <= 1'b0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !in_last) begin
                    state_d = full ? StDiscard : StRecv;
                    quiet_d = 1'b0;
                end
            end
            StRecv: begin
                if (flush) begin
                    state_d = (in_valid && in_last) ? StIdle : StDiscard;
                    quiet_d = 1'b1;
                end else if (in_valid) begin
                    if (in_last) begin
                        state_d = StIdle;
                    end else if (oversize) begin
                        state_d = StDiscard;
                        quiet_d = 1'b0;
                    end
                end
            end
            StDiscard: begin
                if (in_valid && in_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: byte write, commit and drop decisions
    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        drop   = 1'b0;
        wr_off = '0;
        bcnt_d = bcnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (full) begin
                        drop = in_last;
                    end else begin
                        wr_en  = 1'b1;
                        bcnt_d = LEN_W'(1);
                        if (in_last) begin
                            drop   = in_err;
                            commit = !in_err;
                        end
                    end
                end
            end
            StRecv: begin
                if (in_valid && !flush) begin
                    if (oversize) begin
                        drop = in_last;
                    end else begin
                        wr_en  = 1'b1;
                        wr_off = bcnt_q;
                        bcnt_d = bcnt_q + LEN_W'(1);
                        if (in_last) begin
                            drop   = in_err;
                            commit = !in_err;
                        end
                    end
                end
            end
            StDiscard: drop = in_valid && in_last && !quiet_q;
            default: ;
        endcase
    end

    // Queue pointers; flush is applied first so a same-cycle byte sees the empty queue.
    always_comb begin
        wp_base = flush ? '0 : wp_q;
        rp_base = flush ? '0 : rp_q;
        n_base  = flush ? '0 : n_q;
        pop_ok  = pop && !flush && (n_q != '0);
        wp_d    = commit ? wp_base + PTR_W'(1) : wp_base;
        rp_d    = pop_ok ? rp_base + PTR_W'(1) : rp_base;
        n_d     = n_base + Q_W'(commit) - Q_W'(pop_ok);
        if (drop_clr) begin
            cnt_d = '0;
        end else if (drop && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign wr_word = SLOT_ADDR_W'(wr_off >> NB_W);
    assign wr_addr = {wp_base, wr_word};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if ((wr_off & LANE_MASK) == LEN_W'(b)) mem[wr_addr][8*b +: 8] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            rd_data_q <= '0;
            for (int s = 0; s < int'(NSLOTS); s++) len_q[s] <= '0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            rd_data_q <= mem[{rp_q, rd_addr}];
            if (commit) len_q[wp_base] <= bcnt_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign nframes     = n_q;
    assign frame_avail = (n_q != '0);
    assign head_len    = (n_q != '0) ? len_q[rp_q] : '0;
    assign drop_cnt    = cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_frame_queue.sv
// Bench for the RX frame queue: vector table, directed corner cases and a randomized
// run against a frame-level queue model.
module tb_iob_eth_rx_frame_queue;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NSLOTS      = 4;
    localparam int unsigned SLOT_ADDR_W = 9;
    localparam int unsigned CNT_W       = 4;
    localparam int MAXB = 2048;
    localparam int CMAX = 15;

    logic                   clk, rst_n;
    logic                   in_valid, in_last, in_err, flush, pop, drop_clr;
    logic [7:0]             in_data;
    logic [SLOT_ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   frame_avail;
    logic [2:0]             nframes;
    logic [11:0]            head_len;
    logic [CNT_W-1:0]       drop_cnt;

    iob_eth_rx_frame_queue #(
        .DATA_W(DATA_W), .NSLOTS(NSLOTS), .SLOT_ADDR_W(SLOT_ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_err(in_err), .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data), .pop(pop),
        .frame_avail(frame_avail), .nframes(nframes), .head_len(head_len),
        .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    typedef struct { int len; bit err; int npop; int exp_n; int exp_head; int exp_drop; } vec_t;
    typedef struct { int id; int len; } frm_t;

    vec_t vecs[21];
    frm_t mq[$];
    int   mdrop;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [7:0] fbyte(input int id, input int i);
        return 8'((id * 37 + i) & 255);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit last, input bit err, input bit p);
        in_valid = 1'b1; in_data = d; in_last = last; in_err = err; pop = p;
        step();
        in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0; pop = 1'b0;
    endtask

    task automatic send_frame(input int id, input int len, input bit err, input int pop_at,
                              input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step();
            drive_byte(fbyte(id, i), i == len - 1,
                       (i == len - 1) ? err : 1'($urandom_range(0, 1)), i == pop_at);
        end
    endtask

    task automatic pop_once();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic read_word(input int a, output logic [31:0] d);
        rd_addr = SLOT_ADDR_W'(a);
        step();
        d = rd_data;
    endtask

    task automatic check_outputs(input string tag, input int en, input int eh, input int ed);
        check({tag, " nframes"}, 64'(nframes), 64'(en));
        check({tag, " frame_avail"}, 64'(frame_avail), 64'(en != 0));
        check({tag, " head_len"}, 64'(head_len), 64'(eh));
        check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(ed));
    endtask

    task automatic check_head(input int id, input int len);
        logic [31:0] got, e, m;
        for (int w = 0; w < (len + 3) / 4; w++) begin
            e = '0; m = '0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < len) begin
                    e[8*b +: 8] = fbyte(id, w * 4 + b);
                    m[8*b +: 8] = 8'hFF;
                end
            end
            read_word(w, got);
            check($sformatf("head id %0d word %0d", id, w), 64'(got & m), 64'(e));
        end
    endtask

    // Frame-level model: admission decided at the first byte, then pop, then commit/drop.
    task automatic model_frame(input int id, input int len, input bit err, input int pop_at);
        bit   acc;
        frm_t f;
        acc = (mq.size() != NSLOTS);
        if (pop_at >= 0 && mq.size() > 0) void'(mq.pop_front());
        if (acc && !err && len <= MAXB) begin
            f.id = id; f.len = len;
            mq.push_back(f);
        end else if (mdrop < CMAX) begin
            mdrop++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        vecs = '{
            '{60, 1'b0, 0, 1, 60, 0}, '{61, 1'b0, 0, 2, 60, 0}, '{62, 1'b0, 0, 3, 60, 0},
            '{63, 1'b0, 0, 4, 60, 0}, '{1, 1'b0, 0, 4, 60, 1},  '{0, 1'b0, 1, 3, 61, 1},
            '{0, 1'b0, 1, 2, 62, 1},  '{0, 1'b0, 1, 1, 63, 1},  '{0, 1'b0, 1, 0, 0, 1},
            '{0, 1'b0, 1, 0, 0, 1},   '{30, 1'b1, 0, 0, 0, 2},  '{46, 1'b0, 0, 1, 46, 2},
            '{0, 1'b0, 1, 0, 0, 2},   '{MAXB + 10, 1'b0, 0, 0, 0, 3},
            '{100, 1'b0, 0, 1, 100, 3}, '{MAXB, 1'b0, 0, 2, 100, 3},
            '{1, 1'b1, 0, 2, 100, 4}, '{1, 1'b0, 0, 3, 100, 4}, '{0, 1'b0, 1, 2, MAXB, 4},
            '{0, 1'b0, 1, 1, 1, 4},   '{0, 1'b0, 1, 0, 0, 4}
        };
        clk = 0; rst_n = 0;
        in_valid = 0; in_data = 0; in_last = 0; in_err = 0;
        flush = 0; pop = 0; drop_clr = 0; rd_addr = 0;
        repeat (3) step();
        rst_n = 1;
        step();
        check_outputs("reset", 0, 0, 0);
        check("reset rd_data", 64'(rd_data), 64'(0));

        // 64-byte frame of 0x00..0x3F
        send_frame(0, 64, 1'b0, -1, 1'b0);
        check_outputs("frame64", 1, 64, 0);
        read_word(0, w);
        check("frame64 word0", 64'(w), 64'h03020100);
        read_word(15, w);
        check("frame64 word15", 64'(w), 64'h3F3E3D3C);
        pop_once();
        check_outputs("frame64 pop", 0, 0, 0);

        for (int k = 0; k < 21; k++) begin
            if (vecs[k].len > 0) send_frame(100 + k, vecs[k].len, vecs[k].err, -1, 1'b0);
            for (int p = 0; p < vecs[k].npop; p++) pop_once();
            check_outputs($sformatf("vec%0d", k), vecs[k].exp_n, vecs[k].exp_head,
                          vecs[k].exp_drop);
        end

        // Full queue: pop on the first byte does not admit the frame; commit+pop together
        for (int k = 0; k < 4; k++) send_frame(200 + k, 10, 1'b0, -1, 1'b0);
        check_outputs("fill", 4, 10, 4);
        send_frame(204, 8, 1'b0, 0, 1'b0);
        check_outputs("full+pop", 3, 10, 5);
        send_frame(205, 12, 1'b0, 11, 1'b0);
        check_outputs("commit+pop", 3, 10, 5);
        check_head(202, 10);
        flush = 1; step(); flush = 0;
        check_outputs("flush", 0, 0, 5);

        // Flush mid-frame swallows the remainder silently
        for (int i = 0; i < 20; i++) drive_byte(fbyte(300, i), 1'b0, 1'b0, 1'b0);
        flush = 1; step(); flush = 0;
        for (int i = 20; i < 50; i++) drive_byte(fbyte(300, i), i == 49, 1'b0, 1'b0);
        send_frame(7, 10, 1'b0, -1, 1'b0);
        check_outputs("midflush", 1, 10, 5);
        check_head(7, 10);
        flush = 1;
        drive_byte(fbyte(8, 0), 1'b1, 1'b0, 1'b0);
        flush = 0;
        check_outputs("flush+byte", 1, 1, 5);
        check_head(8, 1);

        // Drop counter saturation and clear priority
        for (int k = 0; k < 12; k++) send_frame(400 + k, 1, 1'b1, -1, 1'b0);
        check_outputs("saturate", 1, 1, 15);
        drop_clr = 1;
        send_frame(420, 1, 1'b1, -1, 1'b0);
        drop_clr = 0;
        check_outputs("drop_clr", 1, 1, 0);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) drive_byte(fbyte(500, i), 1'b0, 1'b0, 1'b0);
        rst_n = 0;
        #1;
        check_outputs("midreset", 0, 0, 0);
        check("midreset rd_data", 64'(rd_data), 64'(0));
        step();
        rst_n = 1;
        step();
        send_frame(501, 9, 1'b0, -1, 1'b0);
        check_outputs("post reset", 1, 9, 0);
        check_head(501, 9);

        // Randomized run against the model
        flush = 1; drop_clr = 1; step(); flush = 0; drop_clr = 0;
        mq.delete();
        mdrop = 0;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                int len, pop_at;
                bit err;
                len    = $urandom_range(1, 70);
                err    = ($urandom_range(0, 7) == 0);
                pop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                model_frame(1000 + it, len, err, pop_at);
                send_frame(1000 + it, len, err, pop_at, 1'b1);
            end else begin
                if (mq.size() > 0) begin
                    check_head(mq[0].id, mq[0].len);
                    void'(mq.pop_front());
                end
                pop_once();
            end
            check_outputs($sformatf("rnd%0d", it), mq.size(),
                          (mq.size() > 0) ? mq[0].len : 0, mdrop);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
